// File: rtl/main_slave_driver.sv
// main_slave_driver: loads input elements into `main` over its slave memory port, pulses start,
// counts run cycles to done, then streams results back out. Optional watchdog: MAIN_DRV_TIMEOUT_EN.
module main_slave_driver #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned ELEM_W  = 32,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 200000000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                go,
    input  logic [ADDR_W-1:0]   rd_base,
    input  logic [ADDR_W-1:0]   rd_count,
    input  logic                ld_valid,
    input  logic                ld_last,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic [ELEM_W-1:0]   ld_data,
    output logic                ld_ready,
    output logic                start_port,
    input  logic                done_port,
    output logic [1:0]          S_oe_ram,
    output logic [1:0]          S_we_ram,
    output logic [2*ADDR_W-1:0] S_addr_ram,
    output logic [2*DATA_W-1:0] S_Wdata_ram,
    output logic [13:0]         S_data_ram_size,
    input  logic [2*DATA_W-1:0] Sout_Rdata_ram,
    input  logic [1:0]          Sout_DataRdy,
    output logic                rb_valid,
    output logic [ELEM_W-1:0]   rb_data,
    input  logic                rb_ready,
    output logic                busy,
    output logic                finished,
    output logic                timed_out,
    output logic [CNT_W-1:0]    cyc_count
);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ELEM_W / 8);
    localparam logic [6:0]        SIZE = 7'(ELEM_W);

    if (TIMEOUT == 0 || DATA_W < ELEM_W) begin : g_bad_cfg
        $error("main_slave_driver: TIMEOUT must be nonzero and DATA_W >= ELEM_W");
    end

    typedef enum logic [2:0] {
        IDLE, LD_WAIT, LD_REQ, START, RUN, RD_REQ, RD_OUT, FIN
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [ADDR_W-1:0]   r_rd_cnt;
    logic [ADDR_W-1:0]   r_rd_idx;
    logic                r_ld_last;
    logic                r_ld_ready;
    logic                r_start;
    logic                r_oe;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [ELEM_W-1:0]   r_wdata;
    logic [6:0]          r_size;
    logic                r_rb_valid;
    logic [ELEM_W-1:0]   r_rb_data;
    logic                r_busy;
    logic                r_finished;
    logic                r_timed_out;
    logic [CNT_W-1:0]    r_cyc;
    logic [ADDR_W-1:0]   w_next_addr;
    logic                w_unused;

    assign w_next_addr = r_rd_addr + STEP;
    assign w_unused    = ^{Sout_Rdata_ram[2*DATA_W-1:ELEM_W], Sout_DataRdy[1]};

    assign ld_ready        = r_ld_ready;
    assign start_port      = r_start;
    assign S_oe_ram        = {1'b0, r_oe};
    assign S_we_ram        = {1'b0, r_we};
    assign S_addr_ram      = {{ADDR_W{1'b0}}, r_addr};
    assign S_Wdata_ram     = {{DATA_W{1'b0}}, DATA_W'(r_wdata)};
    assign S_data_ram_size = {7'd0, r_size};
    assign rb_valid        = r_rb_valid;
    assign rb_data         = r_rb_data;
    assign busy            = r_busy;
    assign finished        = r_finished;
    assign timed_out       = r_timed_out;
    assign cyc_count       = r_cyc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rd_addr   <= '0;
            r_rd_cnt    <= '0;
            r_rd_idx    <= '0;
            r_ld_last   <= 1'b0;
            r_ld_ready  <= 1'b0;
            r_start     <= 1'b0;
            r_oe        <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_size      <= '0;
            r_rb_valid  <= 1'b0;
            r_rb_data   <= '0;
            r_busy      <= 1'b0;
            r_finished  <= 1'b0;
            r_timed_out <= 1'b0;
            r_cyc       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (go) begin
                        r_rd_addr   <= rd_base;
                        r_rd_cnt    <= rd_count;
                        r_rd_idx    <= '0;
                        r_cyc       <= '0;
                        r_timed_out <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= LD_WAIT;
                    end
                end
                LD_WAIT: begin
                    // ready is raised one cycle after valid is seen; the source holds valid until then
                    if (ld_valid && r_ld_ready) begin
                        r_ld_ready <= 1'b0;
                        r_ld_last  <= ld_last;
                        r_we       <= 1'b1;
                        r_addr     <= ld_addr;
                        r_wdata    <= ld_data;
                        r_size     <= SIZE;
                        r_state    <= LD_REQ;
                    end else begin
                        r_ld_ready <= ld_valid;
                    end
                end
                LD_REQ: begin
                    if (Sout_DataRdy[0]) begin
                        r_we    <= 1'b0;
                        r_addr  <= '0;
                        r_wdata <= '0;
                        r_size  <= '0;
                        if (r_ld_last) begin
                            r_start <= 1'b1;
                            r_cyc   <= CNT_W'(1);
                            r_state <= START;
                        end else begin
                            r_state <= LD_WAIT;
                        end
                    end
                end
                START: begin
                    r_start <= 1'b0;
                    r_state <= RUN;
                end
                RUN: begin
                    if (done_port) begin
                        if (r_rd_cnt != '0) begin
                            r_oe    <= 1'b1;
                            r_addr  <= r_rd_addr;
                            r_size  <= SIZE;
                            r_state <= RD_REQ;
                        end else begin
                            r_finished <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= FIN;
                        end
`ifdef MAIN_DRV_TIMEOUT_EN
                    end else if (r_cyc >= CNT_W'(TIMEOUT)) begin
                        r_timed_out <= 1'b1;
                        r_finished  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= FIN;
`endif
                    end else if (r_cyc != '1) begin
                        r_cyc <= r_cyc + CNT_W'(1);
                    end
                end
                RD_REQ: begin
                    if (Sout_DataRdy[0]) begin
                        r_oe       <= 1'b0;
                        r_addr     <= '0;
                        r_size     <= '0;
                        r_rb_data  <= Sout_Rdata_ram[ELEM_W-1:0];
                        r_rb_valid <= 1'b1;
                        r_state    <= RD_OUT;
                    end
                end
                RD_OUT: begin
                    if (rb_ready) begin
                        r_rb_valid <= 1'b0;
                        if (r_rd_idx + ADDR_W'(1) == r_rd_cnt) begin
                            r_finished <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= FIN;
                        end else begin
                            r_rd_idx  <= r_rd_idx + ADDR_W'(1);
                            r_rd_addr <= w_next_addr;
                            r_oe      <= 1'b1;
                            r_addr    <= w_next_addr;
                            r_size    <= SIZE;
                            r_state   <= RD_REQ;
                        end
                    end
                end
                FIN: begin
                    r_finished <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_main_slave_driver.sv
// Self-checking bench for main_slave_driver: stub `main` memory/done model plus scoreboard queues.
module tb_main_slave_driver;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         go = 1'b0;
    logic [9:0]   rd_base = '0;
    logic [9:0]   rd_count = '0;
    logic         ld_valid = 1'b0;
    logic         ld_last = 1'b0;
    logic [9:0]   ld_addr = '0;
    logic [31:0]  ld_data = '0;
    logic         ld_ready;
    logic         start_port;
    logic         done_port = 1'b0;
    logic [1:0]   S_oe_ram;
    logic [1:0]   S_we_ram;
    logic [19:0]  S_addr_ram;
    logic [127:0] S_Wdata_ram;
    logic [13:0]  S_data_ram_size;
    logic [127:0] Sout_Rdata_ram;
    logic [1:0]   Sout_DataRdy;
    logic         rb_valid;
    logic [31:0]  rb_data;
    logic         rb_ready;
    logic         busy;
    logic         finished;
    logic         timed_out;
    logic [31:0]  cyc_count;

    int n_checks = 0;
    int n_fail = 0;

    int unsigned rdy_dly = 0;
    int unsigned rb_dly = 0;
    int unsigned acc_wait = 0;
    int unsigned rb_wait = 0;
    int start_cnt = 0;
    int fin_cnt = 0;
    int both_seen = 0;
    int unstable = 0;
    int bus_bad = 0;

    logic [31:0] mem [0:1023];
    logic [9:0]  exp_wr_addr[$], obs_wr_addr[$], exp_rd_addr[$], obs_rd_addr[$];
    logic [31:0] exp_wr_data[$], obs_wr_data[$], exp_rb[$], obs_rb[$];

    logic        hold_pend = 1'b0;
    logic [1:0]  hold_oe, hold_we;
    logic [19:0] hold_addr;
    logic [127:0] hold_wdata;
    logic        rb_hold = 1'b0;
    logic [31:0] rb_prev;

    main_slave_driver #(
        .ADDR_W (10),
        .DATA_W (64),
        .ELEM_W (32),
        .CNT_W  (32),
        .TIMEOUT(20)
    ) dut (
        .clock          (clk),
        .reset          (reset),
        .go             (go),
        .rd_base        (rd_base),
        .rd_count       (rd_count),
        .ld_valid       (ld_valid),
        .ld_last        (ld_last),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data),
        .ld_ready       (ld_ready),
        .start_port     (start_port),
        .done_port      (done_port),
        .S_oe_ram       (S_oe_ram),
        .S_we_ram       (S_we_ram),
        .S_addr_ram     (S_addr_ram),
        .S_Wdata_ram    (S_Wdata_ram),
        .S_data_ram_size(S_data_ram_size),
        .Sout_Rdata_ram (Sout_Rdata_ram),
        .Sout_DataRdy   (Sout_DataRdy),
        .rb_valid       (rb_valid),
        .rb_data        (rb_data),
        .rb_ready       (rb_ready),
        .busy           (busy),
        .finished       (finished),
        .timed_out      (timed_out),
        .cyc_count      (cyc_count)
    );

    always #5 clk = ~clk;

    // Stub slave: completes an access after rdy_dly extra cycles; upper read bits carry junk
    assign Sout_DataRdy   = {1'b0, (S_oe_ram[0] | S_we_ram[0]) && (acc_wait >= rdy_dly)};
    assign Sout_Rdata_ram = S_oe_ram[0] ? {64'h0123_4567_89AB_CDEF, 32'hA5A5_5A5A, mem[S_addr_ram[9:0]]} : '0;
    assign rb_ready       = (rb_wait >= rb_dly);

    always @(posedge clk) begin
        if (reset) begin
            acc_wait  <= 0;
            rb_wait   <= 0;
            hold_pend <= 1'b0;
            rb_hold   <= 1'b0;
        end else begin
            acc_wait <= ((S_oe_ram[0] | S_we_ram[0]) && !Sout_DataRdy[0]) ? acc_wait + 1 : 0;
            rb_wait  <= (rb_valid && !rb_ready) ? rb_wait + 1 : 0;
            if (S_we_ram[0] && Sout_DataRdy[0]) begin
                mem[S_addr_ram[9:0]] <= S_Wdata_ram[31:0];
                obs_wr_addr.push_back(S_addr_ram[9:0]);
                obs_wr_data.push_back(S_Wdata_ram[31:0]);
            end
            if (S_oe_ram[0] && Sout_DataRdy[0]) obs_rd_addr.push_back(S_addr_ram[9:0]);
            if (rb_valid && rb_ready) obs_rb.push_back(rb_data);
            if (start_port) start_cnt <= start_cnt + 1;
            if (finished) fin_cnt <= fin_cnt + 1;
            if (S_oe_ram[0] && S_we_ram[0]) both_seen <= both_seen + 1;
            if (S_oe_ram[1] || S_we_ram[1] || S_addr_ram[19:10] != 0 || S_Wdata_ram[127:32] != 0 ||
                S_data_ram_size[13:7] != 0 ||
                ((S_oe_ram[0] || S_we_ram[0]) && S_data_ram_size[6:0] != 7'd32))
                bus_bad <= bus_bad + 1;
            if (hold_pend && (S_oe_ram != hold_oe || S_we_ram != hold_we ||
                              S_addr_ram != hold_addr || S_Wdata_ram != hold_wdata))
                unstable <= unstable + 1;
            hold_pend  <= (S_oe_ram[0] | S_we_ram[0]) && !Sout_DataRdy[0];
            hold_oe    <= S_oe_ram;
            hold_we    <= S_we_ram;
            hold_addr  <= S_addr_ram;
            hold_wdata <= S_Wdata_ram;
            if (rb_hold && (!rb_valid || rb_data != rb_prev)) unstable <= unstable + 1;
            rb_hold <= rb_valid && !rb_ready;
            rb_prev <= rb_data;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation time limit reached, required completion");
        $fatal(1, "global timeout");
    end

    task automatic clear_queues();
        exp_wr_addr.delete(); obs_wr_addr.delete(); exp_wr_data.delete(); obs_wr_data.delete();
        exp_rd_addr.delete(); obs_rd_addr.delete(); exp_rb.delete(); obs_rb.delete();
    endtask

    task automatic start_job(input logic [9:0] base, input logic [9:0] cnt);
        @(posedge clk); #1;
        go = 1'b1; rd_base = base; rd_count = cnt;
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    task automatic load_elem(input logic [9:0] a, input logic [31:0] d, input logic last);
        bit ok = 0;
        exp_wr_addr.push_back(a);
        exp_wr_data.push_back(d);
        ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = last;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (ld_ready) ok = 1;
        end
        @(posedge clk); #1;
        ld_valid = 1'b0; ld_last = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ld_handshake: ld_ready never seen for addr %0h, required 1", a);
        end
    endtask

    task automatic wait_start_and_done(input int n, input bit raise_done);
        bit ok = 0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            if (start_port) ok = 1;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL start_seen: start_port never asserted, required 1");
        end
        @(negedge clk);
        n_checks++;
        if (start_port !== 1'b0) begin
            n_fail++;
            $display("FAIL start_width: start_port=%0b one cycle later, required 0", start_port);
        end
        if (raise_done) begin
            repeat (n - 1) @(posedge clk);
            #1 done_port = 1'b1;
            @(posedge clk); #1 done_port = 1'b0;
            @(negedge clk);
            n_checks++;
            if (cyc_count !== 32'(n)) begin
                n_fail++;
                $display("FAIL cyc_count: got %0d, required %0d", cyc_count, n);
            end
        end
    endtask

    task automatic wait_finished();
        bit ok = 0;
        for (int k = 0; k < 600 && !ok; k++) begin
            @(negedge clk);
            if (finished) ok = 1;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL finished_seen: finished never pulsed, required 1");
        end
    endtask

    task automatic compare_traffic(input string tag);
        n_checks++;
        if (obs_wr_addr.size() != exp_wr_addr.size()) begin
            n_fail++;
            $display("FAIL %s_wr_count: got %0d writes, required %0d", tag, obs_wr_addr.size(), exp_wr_addr.size());
        end
        while (exp_wr_addr.size() > 0 && obs_wr_addr.size() > 0) begin
            logic [9:0] ea, oa;
            logic [31:0] ed, od;
            ea = exp_wr_addr.pop_front(); oa = obs_wr_addr.pop_front();
            ed = exp_wr_data.pop_front(); od = obs_wr_data.pop_front();
            n_checks++;
            if (oa !== ea || od !== ed) begin
                n_fail++;
                $display("FAIL %s_wr: got addr %0h data %0h, required addr %0h data %0h", tag, oa, od, ea, ed);
            end
        end
        n_checks++;
        if (obs_rd_addr.size() != exp_rd_addr.size()) begin
            n_fail++;
            $display("FAIL %s_rd_count: got %0d reads, required %0d", tag, obs_rd_addr.size(), exp_rd_addr.size());
        end
        while (exp_rd_addr.size() > 0 && obs_rd_addr.size() > 0) begin
            logic [9:0] ea, oa;
            ea = exp_rd_addr.pop_front(); oa = obs_rd_addr.pop_front();
            n_checks++;
            if (oa !== ea) begin
                n_fail++;
                $display("FAIL %s_rd_addr: got %0h, required %0h", tag, oa, ea);
            end
        end
        n_checks++;
        if (obs_rb.size() != exp_rb.size()) begin
            n_fail++;
            $display("FAIL %s_rb_count: got %0d elements, required %0d", tag, obs_rb.size(), exp_rb.size());
        end
        while (exp_rb.size() > 0 && obs_rb.size() > 0) begin
            logic [31:0] e, o;
            e = exp_rb.pop_front(); o = obs_rb.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s_rb_data: got %0h, required %0h", tag, o, e);
            end
        end
        n_checks++;
        if (both_seen != 0 || bus_bad != 0 || unstable != 0) begin
            n_fail++;
            $display("FAIL %s_bus_rules: oe&we=%0d bad_bus=%0d unstable=%0d, required 0 0 0", tag, both_seen, bus_bad, unstable);
        end
    endtask

    task automatic test_reset();
        logic [267:0] all_out;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        all_out = {ld_ready, start_port, S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
                   rb_valid, rb_data, busy, finished, timed_out, cyc_count};
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %0h, required 0", all_out);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (start_cnt != 0 || busy !== 1'b0 || ld_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_quiet: starts=%0d busy=%0b ld_ready=%0b, required 0 0 0", start_cnt, busy, ld_ready);
        end
    endtask

    task automatic test_load_run_readback();
        int f0;
        clear_queues();
        rdy_dly = 0; rb_dly = 0;
        f0 = fin_cnt;
        start_job(10'h000, 10'd5);
        for (int i = 0; i < 5; i++) begin
            logic [31:0] d;
            d = $urandom;
            exp_rd_addr.push_back(10'(i * 4));
            exp_rb.push_back(d);
            load_elem(10'(i * 4), d, i == 4);
        end
        wait_start_and_done(10, 1'b1);
        wait_finished();
        repeat (3) @(negedge clk);
        n_checks++;
        if (fin_cnt - f0 != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_finish: pulses=%0d busy=%0b, required 1 0", fin_cnt - f0, busy);
        end
        compare_traffic("basic");
    endtask

    task automatic test_back_to_back_stall();
        clear_queues();
        rdy_dly = 3; rb_dly = 4;
        start_job(10'h020, 10'd3);
        for (int i = 0; i < 3; i++) begin
            logic [31:0] d;
            d = $urandom;
            exp_rd_addr.push_back(10'(32 + i * 4));
            exp_rb.push_back(d);
            load_elem(10'(32 + i * 4), d, i == 2);
        end
        wait_start_and_done(4, 1'b1);
        wait_finished();
        compare_traffic("stall");
        rdy_dly = 0; rb_dly = 0;
    endtask

    task automatic test_wrap();
        clear_queues();
        start_job(10'h3FC, 10'd2);
        exp_rd_addr.push_back(10'h3FC); exp_rb.push_back(32'hCAFE_0001);
        exp_rd_addr.push_back(10'h000); exp_rb.push_back(32'h0BAD_F00D);
        load_elem(10'h3FC, 32'hCAFE_0001, 1'b0);
        load_elem(10'h000, 32'h0BAD_F00D, 1'b1);
        wait_start_and_done(3, 1'b1);
        wait_finished();
        compare_traffic("wrap");
    endtask

`ifdef MAIN_DRV_TIMEOUT_EN
    task automatic test_timeout();
        clear_queues();
        start_job(10'h000, 10'd4);
        load_elem(10'h010, 32'h1234_5678, 1'b1);
        wait_start_and_done(0, 1'b0);
        wait_finished();
        n_checks++;
        if (timed_out !== 1'b1 || cyc_count !== 32'd20) begin
            n_fail++;
            $display("FAIL timeout: timed_out=%0b cyc=%0d, required 1 20", timed_out, cyc_count);
        end
        compare_traffic("timeout");
        start_job(10'h000, 10'd0);
        @(negedge clk);
        n_checks++;
        if (timed_out !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: timed_out=%0b after go, required 0", timed_out);
        end
        load_elem(10'h000, 32'h1, 1'b1);
        wait_start_and_done(2, 1'b1);
        wait_finished();
    endtask
`endif

    task automatic test_reset_mid_run();
        int s0;
        clear_queues();
        start_job(10'h000, 10'd1);
        load_elem(10'h008, 32'h5555_AAAA, 1'b1);
        wait_start_and_done(0, 1'b0);
        repeat (5) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || timed_out !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_run: busy=%0b timed_out=%0b, required 1 0", busy, timed_out);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || cyc_count !== 32'd0 || S_oe_ram !== 2'b00) begin
            n_fail++;
            $display("FAIL async_reset: busy=%0b cyc=%0d oe=%0b, required 0 0 0", busy, cyc_count, S_oe_ram);
        end
        @(posedge clk); #1 reset = 1'b0;
        s0 = start_cnt;
        repeat (5) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || ld_ready !== 1'b0 || start_cnt != s0) begin
            n_fail++;
            $display("FAIL post_reset_idle: busy=%0b ld_ready=%0b starts=%0d, required 0 0 0", busy, ld_ready, start_cnt - s0);
        end
    endtask

    initial begin
        test_reset();
        test_load_run_readback();
        test_back_to_back_stall();
        test_wrap();
`ifdef MAIN_DRV_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
